// File: rtl/num_scan_disp.sv
// ============================================================================
// num_scan_disp
//
// Purpose:
//   Keeps a four-deep history of 3-bit values from an upstream sequencer.
//   The history is shown on a 4-digit, time-multiplexed 7-segment display.
//   The block can also pulse when the history equals a target pattern.
//   It counts accepted samples that differ from the sample before them.
//
// Parameters:
//   SCAN_DIV   - clock cycles each digit is held on the display (1..255)
//   PATTERN    - target history in octal digits:
//                oldest digit in [11:9], newest digit in [2:0]
//
// Ports:
//   clk        - single clock; all state updates on its rising edge
//   rst        - synchronous, active-high reset
//   number     - 3-bit value from the upstream sequencer
//   sample_en  - accept number on this edge
//   seg        - active-low segments, bit order {g,f,e,d,c,b,a}
//   an         - active-low one-hot digit enable; an[i] selects digit i
//   match      - one-cycle pulse after an accepted sample completes PATTERN
//   change_cnt - count of accepted samples that differ from the previous
//                sample; saturates at 255
//
// Configuration:
//   PATTERN_MATCH_EN - when defined, the block builds the pattern comparator
//                      and the match register. When undefined, match is
//                      tied low and all other behaviour is unchanged.
// ============================================================================
module num_scan_disp #(
    parameter int          SCAN_DIV = 4,
    parameter logic [11:0] PATTERN  = 12'o0136
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] number,
    input  logic       sample_en,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       match,
    output logic [7:0] change_cnt
);

    // Stop elaboration if a parameter is out of range. A divider wider than
    // 8 bits, or a pattern that is not four octal digits, cannot be built.
    if (SCAN_DIV < 1 || SCAN_DIV > 255 || $bits(PATTERN) != 12) begin : g_bad_param
        $error("num_scan_disp: SCAN_DIV must be 1..255 and PATTERN 12 bits");
    end

    localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

    logic [2:0] hist_q [4];
    logic [2:0] hist_d [4];
    logic [2:0] fill_q, fill_d;
    logic [7:0] div_q, div_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] chg_q, chg_d;

    // Scan divider and digit index.
    // The index moves forward on the same edge on which the divider wraps.
    // With SCAN_DIV=1 the divider wraps on every edge.
    always_comb begin
        div_d = div_q;
        idx_d = idx_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            div_d = div_q + 8'd1;
        end
    end

    // Sample history, fill level and change counter.
    // The fill_q != 0 term keeps the first sample after reset from being
    // counted as a change. At that point hist0 holds the reset value, not
    // a real sample.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        chg_d  = chg_q;
        if (sample_en) begin
            hist_d[3] = hist_q[2];
            hist_d[2] = hist_q[1];
            hist_d[1] = hist_q[0];
            hist_d[0] = number;
            if (fill_q != 3'd4) begin
                fill_d = fill_q + 3'd1;
            end
            if (fill_q != 3'd0 && number != hist_q[0] && chg_q != 8'hFF) begin
                chg_d = chg_q + 8'd1;
            end
        end
    end

    // Registers for the datapath. Reset takes priority over sample_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '{default: '0};
            fill_q <= '0;
            div_q  <= '0;
            idx_q  <= '0;
            chg_q  <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            div_q  <= div_d;
            idx_q  <= idx_d;
            chg_q  <= chg_d;
        end
    end

`ifdef PATTERN_MATCH_EN
    logic match_q, match_d;

    // Compare the history as it will be after this edge. fill_q >= 3 means
    // the new fill will be 4. Each accepted sample is judged on its own, so
    // consecutive hits give consecutive pulses.
    always_comb begin
        match_d = 1'b0;
        if (sample_en && fill_q >= 3'd3 &&
            {hist_q[2], hist_q[1], hist_q[0], number} == PATTERN) begin
            match_d = 1'b1;
        end
    end

    // Match pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    assign match = match_q;
`else
    assign match = 1'b0;
`endif

    logic [2:0] cur_digit;
    logic [6:0] cur_code;

    // Display decode. This logic is purely combinational from the registered
    // index, history and fill, so a new sample shows up on the next cycle.
    always_comb begin
        cur_digit = hist_q[idx_q];
        cur_code  = 7'h7F;
        case (cur_digit)
            3'd0:    cur_code = 7'h40;
            3'd1:    cur_code = 7'h79;
            3'd2:    cur_code = 7'h24;
            3'd3:    cur_code = 7'h30;
            3'd4:    cur_code = 7'h19;
            3'd5:    cur_code = 7'h12;
            3'd6:    cur_code = 7'h02;
            default: cur_code = 7'h78;
        endcase
        // A digit slot that has not been filled since reset stays blank.
        seg = ({1'b0, idx_q} < fill_q) ? cur_code : 7'h7F;
        an  = ~(4'b0001 << idx_q);
    end

    assign change_cnt = chg_q;

endmodule

// File: tb/tb_num_scan_disp.sv
// ============================================================================
// tb_num_scan_disp
//
// Purpose:
//   Self-checking bench for num_scan_disp. It drives two instances from the
//   same inputs: one with SCAN_DIV=4 and one with SCAN_DIV=1. The bench
//   compares both instances every cycle against a behavioural model. The
//   model keeps the history as a queue and works out the scan index from
//   the number of cycles since reset. Hand-written vector tables and
//   sequences pin down the documented corner cases.
// ============================================================================
module tb_num_scan_disp;

    localparam int PAT = 'o0136;

`ifdef PATTERN_MATCH_EN
    localparam bit MATCH_BUILT = 1'b1;
`else
    localparam bit MATCH_BUILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_en = 1'b0;
    logic [2:0] number = 3'd0;

    logic [6:0] seg, seg1;
    logic [3:0] an, an1;
    logic       match, match1;
    logic [7:0] chg, chg1;

    always #5 clk = ~clk;

    num_scan_disp #(.SCAN_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .number     (number),
        .sample_en  (sample_en),
        .seg        (seg),
        .an         (an),
        .match      (match),
        .change_cnt (chg)
    );

    num_scan_disp #(.SCAN_DIV(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .number     (number),
        .sample_en  (sample_en),
        .seg        (seg1),
        .an         (an1),
        .match      (match1),
        .change_cnt (chg1)
    );

    int assert_cnt = 0;
    int fail_cnt   = 0;

    // Reference model state.
    // hq[0] is the newest sample. t counts edges since the last reset.
    int hq[$];
    int t       = 0;
    int m_chg   = 0;
    bit m_match = 1'b0;

    logic [6:0] seg_code [8] = '{7'h40, 7'h79, 7'h24, 7'h30,
                                 7'h19, 7'h12, 7'h02, 7'h78};

    function automatic int expIdx(input int sd);
        return (t / sd) % 4;
    endfunction

    function automatic logic [6:0] expSeg(input int sd);
        int idx = expIdx(sd);
        if (idx < hq.size()) return seg_code[hq[idx]];
        return 7'h7F;
    endfunction

    function automatic logic [3:0] expAn(input int sd);
        logic [3:0] a = 4'hF;
        a[expIdx(sd)] = 1'b0;
        return a;
    endfunction

    task automatic checkOutput(input string name, input int got, input int exp);
        assert_cnt++;
        if (got != exp) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0d)", name, got, exp, t);
        end
    endtask

    // Drive one cycle, advance the model across the edge, then check both
    // DUTs against the model one time unit after the edge.
    task automatic applyStimulus(input bit r, input bit e, input int n);
        int pv;
        rst       = r;
        sample_en = e;
        number    = 3'(n);
        @(posedge clk);
        m_match = 1'b0;
        if (r) begin
            hq.delete();
            t     = 0;
            m_chg = 0;
        end else begin
            t++;
            if (e) begin
                if (hq.size() >= 1 && n != hq[0] && m_chg < 255) m_chg++;
                hq.push_front(n);
                if (hq.size() > 4) void'(hq.pop_back());
                if (hq.size() == 4) begin
                    pv = hq[3] * 512 + hq[2] * 64 + hq[1] * 8 + hq[0];
                    if (pv == PAT && MATCH_BUILT) m_match = 1'b1;
                end
            end
        end
        #1;
        checkOutput("seg_d4",   int'(seg),    int'(expSeg(4)));
        checkOutput("an_d4",    int'(an),     int'(expAn(4)));
        checkOutput("match_d4", int'(match),  int'(m_match));
        checkOutput("chg_d4",   int'(chg),    m_chg);
        checkOutput("seg_d1",   int'(seg1),   int'(expSeg(1)));
        checkOutput("an_d1",    int'(an1),    int'(expAn(1)));
        checkOutput("match_d1", int'(match1), int'(m_match));
        checkOutput("chg_d1",   int'(chg1),   m_chg);
    endtask

    typedef struct {
        bit         r;
        bit         e;
        int         n;
        logic [6:0] s;
        logic [3:0] a;
        bit         m;
        int         c;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkVec(input bit r, input bit e, input int n,
                                   input logic [6:0] s, input logic [3:0] a,
                                   input bit m, input int c);
        vec_t v;
        v.r = r; v.e = e; v.n = n; v.s = s; v.a = a; v.m = m; v.c = c;
        return v;
    endfunction

    initial begin
        int k;
        int n;
        bit e;
        bit r;

        // Accept 0,1,3,6 after reset, then idle. The expected values are for
        // the SCAN_DIV=4 instance. The idle rows drive 7 on number to show
        // that number is ignored while sample_en is low.
        tbl.push_back(mkVec(1, 0, 0, 7'h7F, 4'b1110, 0, 0));
        tbl.push_back(mkVec(0, 1, 0, 7'h40, 4'b1110, 0, 0));
        tbl.push_back(mkVec(0, 1, 1, 7'h79, 4'b1110, 0, 1));
        tbl.push_back(mkVec(0, 1, 3, 7'h30, 4'b1110, 0, 2));
        tbl.push_back(mkVec(0, 1, 6, 7'h30, 4'b1101, MATCH_BUILT, 3));
        for (int i = 5; i <= 7; i++)  tbl.push_back(mkVec(0, 0, 7, 7'h30, 4'b1101, 0, 3));
        for (int i = 8; i <= 11; i++) tbl.push_back(mkVec(0, 0, 7, 7'h79, 4'b1011, 0, 3));
        for (int i = 12; i <= 15; i++) tbl.push_back(mkVec(0, 0, 7, 7'h40, 4'b0111, 0, 3));
        tbl.push_back(mkVec(0, 0, 7, 7'h02, 4'b1110, 0, 3));

        // Reset, then 20 idle cycles: display blank, digit enable scanning.
        applyStimulus(1, 0, 0);
        checkOutput("rst_an",    int'(an),    'b1110);
        checkOutput("rst_seg",   int'(seg),   'h7F);
        checkOutput("rst_match", int'(match), 0);
        checkOutput("rst_chg",   int'(chg),   0);
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, i % 8);

        // Table-driven pattern sequence.
        foreach (tbl[i]) begin
            applyStimulus(tbl[i].r, tbl[i].e, tbl[i].n);
            checkOutput($sformatf("tbl%0d_seg", i),   int'(seg),   int'(tbl[i].s));
            checkOutput($sformatf("tbl%0d_an", i),    int'(an),    int'(tbl[i].a));
            checkOutput($sformatf("tbl%0d_match", i), int'(match), int'(tbl[i].m));
            checkOutput($sformatf("tbl%0d_chg", i),   int'(chg),   tbl[i].c);
        end

        // Reset in the middle of a pattern discards the partial history.
        applyStimulus(1, 0, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 1);
        applyStimulus(0, 1, 3);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 1, 6);
        checkOutput("midrst_seg0",  int'(seg),   'h02);
        checkOutput("midrst_match", int'(match), 0);
        checkOutput("midrst_chg",   int'(chg),   0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0);
        checkOutput("midrst_blank1", int'(seg), 'h7F);

        // Change counter saturates at 255.
        applyStimulus(1, 0, 0);
        for (int i = 0; i < 300; i++) applyStimulus(0, 1, (i % 2 == 0) ? 2 : 5);
        checkOutput("chg_sat",  int'(chg),  255);
        checkOutput("chg1_sat", int'(chg1), 255);
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, (i % 2 == 0) ? 2 : 5);
        checkOutput("chg_hold", int'(chg), 255);

        // SCAN_DIV=1: a sample on the wrap back to digit 0 appears with it.
        applyStimulus(1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0);
        applyStimulus(0, 1, 5);
        checkOutput("div1_an",  int'(an1),  'b1110);
        checkOutput("div1_seg", int'(seg1), 'h12);
        checkOutput("div4_seg", int'(seg),  'h7F);

        // Randomized traffic: alternate windows of uniform values and values
        // biased toward the target pattern.
        applyStimulus(1, 0, 0);
        k = 0;
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 3) != 0);
            if ((i / 50) % 2 == 0) begin
                n = $urandom_range(0, 7);
            end else begin
                n = (PAT >> (9 - 3 * (k % 4))) & 7;
                if ($urandom_range(0, 15) == 0) n = $urandom_range(0, 7);
                if (e) k++;
            end
            applyStimulus(r, e, n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/num_scan_disp.md
NUM_SCAN_DISP -- requirements
Module: num_scan_disp

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 4: clock cycles each display digit is held, legal range 1..255.
REQ-002 The block SHALL have parameter PATTERN, default 12'o0136: target history, oldest digit in [11:9], newest in [2:0].
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port number, input, 3 bits: value from the upstream 3-bit sequencer.
REQ-006 The block SHALL have port sample_en, input, 1 bit: accept number on this edge.
REQ-007 The block SHALL have port seg, output, 7 bits: active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-008 The block SHALL have port an, output, 4 bits: active-low one-hot digit enable; an[i] selects digit i.
REQ-009 The block SHALL have port match, output, 1 bit: one-cycle pulse on PATTERN hit.
REQ-010 The block SHALL have port change_cnt, output, 8 bits: count of accepted samples that differ from the previous sample.

Function
REQ-011 The block SHALL hold a 4-entry x 3-bit history, hist0 = newest, hist3 = oldest.
REQ-012 On an edge with sample_en=1, the block SHALL shift: hist3<=hist2, hist2<=hist1, hist1<=hist0, hist0<=number.
REQ-013 The block SHALL keep fill, 0..4, incremented per accepted sample and saturating at 4.
REQ-014 match SHALL be registered: high for exactly the one cycle after an accepting edge whose new history {hist3,hist2,hist1,hist0} equals PATTERN with new fill=4; low otherwise.
REQ-015 Back-to-back accepted samples SHALL each be evaluated independently; consecutive hits give consecutive match pulses.
REQ-016 change_cnt SHALL increment by 1 on an accepting edge when fill>=1 and number != hist0; it SHALL saturate at 255 and never wrap.
REQ-017 The first accepted sample after reset SHALL never increment change_cnt.
REQ-018 A scan divider SHALL count 0..SCAN_DIV-1; on the edge where it wraps, the digit index SHALL advance 0->1->2->3->0.
REQ-019 With SCAN_DIV=1, the digit index SHALL advance every cycle.
REQ-020 an SHALL be the active-low one-hot form of the digit index (index 0 -> 4'b1110).
REQ-021 seg SHALL display hist[index] when index < fill, else blank (7'h7F).
REQ-022 Segment codes SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78 (hex).
REQ-023 seg and an SHALL be combinational from registered index, history and fill; no latency beyond those registers.
REQ-024 When sample_en and a divider wrap coincide, both updates SHALL occur on the same edge; the next cycle shows the new index with the new history.
REQ-025 When sample_en=0, number SHALL be ignored and history, fill and change_cnt SHALL hold.

Reset
REQ-026 When rst=1 at an edge, the block SHALL clear history, fill, divider, index, match and change_cnt to 0, overriding sample_en.
REQ-027 After reset, outputs SHALL be an=4'b1110, seg=7'h7F, match=0, change_cnt=0.
REQ-028 Reset asserted mid-scan or mid-pattern SHALL discard partial history; a match SHALL require 4 fresh samples.

Configuration
REQ-029 Macro PATTERN_MATCH_EN SHALL control pattern matching.
REQ-030 With PATTERN_MATCH_EN defined, the comparator and match register SHALL be built as in REQ-014.
REQ-031 Without PATTERN_MATCH_EN, match SHALL be tied to 0, no comparator SHALL be built, and all other behaviour SHALL be unchanged.

Verification
REQ-032 Reset, then hold sample_en=0 for 20 cycles -> seg=7'h7F throughout, an cycles 1110,1101,1011,0111 every 4 clocks, change_cnt=0.
REQ-033 Accept 0,1,3,6 on consecutive cycles (macro defined) -> match=1 for one cycle after the 4th sample; digit 0 shows 02, digit 3 shows 40.
REQ-034 Accept 0,1,3 then pulse rst, then accept 6 -> no match; fill=1; only digit 0 non-blank.
REQ-035 Accept 300 samples alternating 2/5 -> change_cnt=255 and stays there.
REQ-036 SCAN_DIV=1, apply sample_en on a divider-wrap edge -> index advances and new hist0 appears on the same following cycle.
REQ-037 Rebuild without PATTERN_MATCH_EN, replay REQ-033 -> match stays 0; seg, an and change_cnt identical to the macro-defined build.
